// File: rtl/spike_enc_pkg.sv
// Shared types and helpers for the 12-taxel AER root responder.
// Event bundle, FSM state encoding and grant-vector decode helpers.
package spike_enc_pkg;

    localparam int ADDR_W  = 4;
    localparam int N_TAXEL = 12;
    localparam int TS_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        CAPTURE,
        WAIT_REL,
        RELEASE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TS_W-1:0]   ts;
    } evt_t;

    // Number of asserted (low) grant lines.
    function automatic logic [3:0] zero_cnt(input logic [N_TAXEL-1:0] g);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < N_TAXEL; i++) begin
            n = n + {3'b000, ~g[i]};
        end
        return n;
    endfunction

    function automatic logic [ADDR_W-1:0] low_idx(input logic [N_TAXEL-1:0] g);
        logic [ADDR_W-1:0] a;
        a = '0;
        for (int i = N_TAXEL - 1; i >= 0; i--) begin
            if (!g[i]) begin
                a = ADDR_W'(i);
            end
        end
        return a;
    endfunction

endpackage

// File: rtl/aer_evt_fifo.sv
// Small synchronous FIFO buffering captured AER events.
// Simultaneous push and pop are accepted even when full.
module aer_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/aer_rx_12.sv
// Root-side responder for the 12-taxel arbiter tree: 4-phase handshake,
// grant decode, timestamping and event buffering toward the encoder.
module aer_rx_12
    import spike_enc_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ACK_TO     = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ro,
    output logic               n_ri,
    input  logic [N_TAXEL-1:0] n_lno,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [ADDR_W-1:0]  ev_addr,
    output logic [TS_W-1:0]    ev_ts,
    output logic               err,
    output logic [15:0]        ev_count
);

    localparam int TO_W = $clog2(ACK_TO + 1);

    logic               r_ro_m;
    logic               r_ro_s;
    logic [N_TAXEL-1:0] r_g_m;
    logic [N_TAXEL-1:0] r_g_s;
    logic [N_TAXEL-1:0] r_g_prev;
    logic [TS_W-1:0]    r_ts;
    logic [TS_W-1:0]    r_ts_lat;
    logic [ADDR_W-1:0]  r_addr;
    logic [3:0]         r_stab;
    logic [TO_W-1:0]    r_to;
    logic [15:0]        r_cnt;
    logic               r_n_ri;
    logic               r_err;
    state_t             r_state;

    state_t             w_state_n;
    logic               w_err_set;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_settled;
    logic [3:0]         w_zeros;
    evt_t               w_push_evt;
    evt_t               w_head;

    assign w_zeros    = zero_cnt(r_g_s);
    assign w_settled  = (r_stab >= 4'(SETTLE_CYC));
    assign w_push_evt = '{addr: r_addr, ts: r_ts_lat};
    assign w_pop      = ev_valid && ev_ready;

    always_comb begin
        w_state_n = r_state;
        w_err_set = 1'b0;
        w_push    = 1'b0;
        unique case (r_state)
            IDLE: begin
                // The tree must not grant while the root is not acked.
                if (r_g_s != '1) begin
                    w_err_set = 1'b1;
                end
                if (r_ro_s && !w_full) begin
                    w_state_n = ACK;
                end
            end
            ACK: begin
                if (w_settled && w_zeros == 4'd1) begin
                    w_state_n = CAPTURE;
                end else if (w_settled && w_zeros > 4'd1) begin
                    w_err_set = 1'b1;
                    w_state_n = WAIT_REL;
                end else if (r_to == TO_W'(ACK_TO - 1)) begin
                    w_err_set = 1'b1;
                    w_state_n = WAIT_REL;
                end
            end
            CAPTURE: begin
                w_push    = 1'b1;
                w_state_n = WAIT_REL;
            end
            WAIT_REL: begin
                if (!r_ro_s) begin
                    w_state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (r_g_s == '1) begin
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ro_m   <= 1'b0;
            r_ro_s   <= 1'b0;
            r_g_m    <= '1;
            r_g_s    <= '1;
            r_g_prev <= '1;
            r_ts     <= '0;
            r_ts_lat <= '0;
            r_addr   <= '0;
            r_stab   <= '0;
            r_to     <= '0;
            r_cnt    <= '0;
            r_n_ri   <= 1'b1;
            r_err    <= 1'b0;
            r_state  <= IDLE;
        end else begin
            r_ro_m   <= ro;
            r_ro_s   <= r_ro_m;
            r_g_m    <= n_lno;
            r_g_s    <= r_g_m;
            r_g_prev <= r_g_s;
            r_ts     <= r_ts + 1'b1;
            r_state  <= w_state_n;
            // Registered so the async tree never sees a decode glitch.
            r_n_ri   <= !(w_state_n inside {ACK, CAPTURE, WAIT_REL});
            if (r_state != ACK || r_g_s != r_g_prev) begin
                r_stab <= '0;
            end else if (r_stab != 4'hF) begin
                r_stab <= r_stab + 1'b1;
            end
            if (r_state != ACK) begin
                r_to <= '0;
            end else begin
                r_to <= r_to + 1'b1;
            end
            if (r_state == IDLE && w_state_n == ACK) begin
                r_ts_lat <= r_ts;
            end
            if (r_state == ACK && w_state_n == CAPTURE) begin
                r_addr <= low_idx(r_g_s);
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_push && r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    aer_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(evt_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_evt),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign n_ri     = r_n_ri;
    assign err      = r_err;
    assign ev_count = r_cnt;
    assign ev_valid = !w_empty;
    assign ev_addr  = w_empty ? '0 : w_head.addr;
    assign ev_ts    = w_empty ? '0 : w_head.ts;

endmodule

// File: tb/tb_aer_rx_12.sv
// Scoreboard bench for aer_rx_12: directed handshakes, queued
// expected events, and an independent monitor draining the FIFO.
module tb_aer_rx_12;
    import spike_enc_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               ro;
    logic               n_ri;
    logic [N_TAXEL-1:0] n_lno;
    logic               ev_valid;
    logic               ev_ready;
    logic [ADDR_W-1:0]  ev_addr;
    logic [TS_W-1:0]    ev_ts;
    logic               err;
    logic [15:0]        ev_count;

    int        n_vec  = 0;
    int        n_fail = 0;
    int        n_pops = 0;
    evt_t      sb[$];
    logic [15:0] cyc;
    logic [15:0] last_ts;
    bit        have_last;

    always #5 clk = ~clk;

    aer_rx_12 dut (
        .clk      (clk),
        .rst      (rst),
        .ro       (ro),
        .n_ri     (n_ri),
        .n_lno    (n_lno),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_addr  (ev_addr),
        .ev_ts    (ev_ts),
        .err      (err),
        .ev_count (ev_count)
    );

    // Bench cycle count since reset; equals the DUT timestamp by definition.
    always @(posedge clk) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 16'd1;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        evt_t e;
        if (!rst && ev_valid && ev_ready) begin
            n_pops++;
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_pop: got addr %0d expected none",
                         ev_addr);
            end else begin
                e = sb.pop_front();
                check("ev_addr", 32'(ev_addr), 32'(e.addr));
                check("ev_ts", 32'(ev_ts), 32'(e.ts));
                if (have_last) begin
                    n_vec++;
                    if (!(ev_ts > last_ts)) begin
                        n_fail++;
                        $display("FAIL ts_order: got %0d expected > %0d",
                                 ev_ts, last_ts);
                    end
                end
                last_ts   = ev_ts;
                have_last = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ro       = 1'b0;
        n_lno    = '1;
        ev_ready = 1'b1;
        repeat (3) tick();
        sb.delete();
        have_last = 1'b0;
        n_pops    = 0;
        rst       = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_nri(input logic v, input int bound,
                            input string nm, output int lat);
        lat = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (n_ri == v) begin
                lat = i;
                break;
            end
        end
        n_vec++;
        if (lat == 0) begin
            n_fail++;
            $display("FAIL %s: got timeout expected n_ri=%0d", nm, v);
        end
    endtask

    // Raise ro and return the timestamp the DUT should latch.
    task automatic req(output logic [15:0] ts);
        int lat;
        ro = 1'b1;
        wait_nri(1'b0, 200, "ack_fall", lat);
        ts = cyc - 16'd1;
        tick();
    endtask

    task automatic finish(input logic [N_TAXEL-1:0] pat, input bit push,
                          input logic [3:0] a, input logic [15:0] ts);
        int lat;
        repeat (2) tick();
        n_lno = pat;
        if (push) sb.push_back('{addr: a, ts: ts});
        repeat (10) tick();
        ro = 1'b0;
        wait_nri(1'b1, 20, "ack_rise", lat);
        tick();
        n_lno = '1;
        repeat (5) tick();
    endtask

    task automatic do_event(input logic [3:0] a);
        logic [15:0] ts;
        req(ts);
        finish(~(12'(1) << a), 1'b1, a, ts);
    endtask

    initial begin
        logic [3:0]  b2b [3] = '{4'd0, 4'd11, 4'd6};
        logic [15:0] ts;
        int          lat;
        int          ones;

        rst = 1'b1; ro = 1'b0; n_lno = '1; ev_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("rst_n_ri", 32'(n_ri), 32'd1);
        check("rst_ev_valid", 32'(ev_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ev_count", 32'(ev_count), 32'd0);
        check("rst_ev_addr", 32'(ev_addr), 32'd0);
        check("rst_ev_ts", 32'(ev_ts), 32'd0);
        do_reset();

        // Single event on taxel 5.
        do_event(4'd5);
        @(negedge clk);
        check("single_count", 32'(ev_count), 32'd1);
        check("single_err", 32'(err), 32'd0);
        check("single_n_ri", 32'(n_ri), 32'd1);
        check("single_pops", 32'(n_pops), 32'd1);

        // Back-to-back taxels 0, 11, 6.
        tick();
        foreach (b2b[i]) do_event(b2b[i]);
        @(negedge clk);
        check("b2b_count", 32'(ev_count), 32'd4);
        check("b2b_pops", 32'(n_pops), 32'd4);
        check("b2b_err", 32'(err), 32'd0);

        // Two grants low: error, no push, handshake completes.
        tick();
        req(ts);
        finish(12'hFFC, 1'b0, 4'd0, ts);
        @(negedge clk);
        check("multi_err", 32'(err), 32'd1);
        check("multi_count", 32'(ev_count), 32'd4);
        check("multi_pops", 32'(n_pops), 32'd4);
        check("multi_n_ri", 32'(n_ri), 32'd1);

        // No grant ever: timeout.
        tick();
        do_reset();
        req(ts);
        repeat (70) tick();
        @(negedge clk);
        check("to_err", 32'(err), 32'd1);
        check("to_n_ri_held", 32'(n_ri), 32'd0);
        tick();
        ro = 1'b0;
        wait_nri(1'b1, 20, "to_release", lat);
        check("to_count", 32'(ev_count), 32'd0);
        tick();

        // Backpressure: fill the FIFO, then a 5th request.
        do_reset();
        ev_ready = 1'b0;
        do_event(4'd1);
        do_event(4'd2);
        do_event(4'd3);
        do_event(4'd4);
        check("bp_valid", 32'(ev_valid), 32'd1);
        ro = 1'b1;
        ones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (n_ri) ones++;
        end
        check("bp_n_ri_held", 32'(ones), 32'd12);
        tick();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        wait_nri(1'b0, 10, "bp_ack", lat);
        check("bp_ack_latency", 32'(lat), 32'd2);
        ts = cyc - 16'd1;
        tick();
        finish(~(12'(1) << 9), 1'b1, 4'd9, ts);
        @(negedge clk);
        check("bp_count", 32'(ev_count), 32'd5);
        check("bp_err", 32'(err), 32'd0);
        tick();
        ev_ready = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        check("bp_pops", 32'(n_pops), 32'd5);
        check("bp_drained", 32'(ev_valid), 32'd0);

        // Reset while parked in WAIT_REL with two events buffered.
        tick();
        do_reset();
        ev_ready = 1'b0;
        do_event(4'd7);
        req(ts);
        repeat (2) tick();
        n_lno = ~(12'(1) << 8);
        repeat (10) tick();
        @(negedge clk);
        check("rm_count", 32'(ev_count), 32'd2);
        check("rm_n_ri", 32'(n_ri), 32'd0);
        tick();
        rst = 1'b1; ro = 1'b0; n_lno = '1;
        @(posedge clk);
        @(negedge clk);
        check("rm_n_ri_after", 32'(n_ri), 32'd1);
        check("rm_valid_after", 32'(ev_valid), 32'd0);
        check("rm_count_after", 32'(ev_count), 32'd0);
        check("rm_err_after", 32'(err), 32'd0);
        sb.delete();
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aer_rx_12.md
Name: aer_rx_12

Overview:
- Synchronous root-side responder for the 12-taxel asynchronous arbiter tree.
- Samples the tree's root request and completes the 4-phase handshake by driving the active-low root acknowledge.
- Identifies the granted taxel from the active-low per-taxel grant lines and encodes it to a 4-bit address.
- Timestamps each event and buffers it in a small FIFO toward the synchronous spike-encoder back end.

Parameters:
- N_TAXEL, 12, number of grant lines and taxel addresses (0..11).
- SETTLE_CYC, 2, cycles the synchronized grant vector must be stable before it is sampled (1..15).
- TS_W, 16, timestamp counter width.
- FIFO_DEPTH, 4, event buffer entries (power of two, ≥2).
- ACK_TO, 64, cycles to wait for a valid grant after ack assertion before flagging an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ro  in  1  asynchronous root request from the arbiter tree; 1 = request.
- n_ri  out  1  root acknowledge, active-low; 0 = ack.
- n_lno  in  N_TAXEL  asynchronous per-taxel grants, active-low; monitored only.
- ev_valid  out  1  event available at FIFO head.
- ev_ready  in  1  consumer accepts head when ev_valid & ev_ready.
- ev_addr  out  4  taxel index of head event.
- ev_ts  out  TS_W  timestamp of head event.
- err  out  1  sticky protocol error.
- ev_count  out  16  saturating count of accepted events.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - n_ri=1, ev_valid=0, err=0, ev_count=0.
  - ev_addr=0, ev_ts=0, FIFO empty, timestamp=0, FSM=IDLE.
- Synchronization:
  - ro and n_lno each pass through a 2-flop synchronizer (ro_s, g_s).
  - No logic uses the raw asynchronous inputs.
- Timestamp: free-running, +1 per cycle, wraps modulo 2^TS_W.
- FSM:
  - IDLE: if ro_s=1 and FIFO not full → ACK, driving n_ri=0 from the next cycle. If FIFO is full, stay in IDLE with n_ri=1; this is backpressure, and no event is lost.
  - ACK: count cycles in which g_s is unchanged; the stability counter resets on any change. When the counter reaches SETTLE_CYC and g_s has exactly one 0 bit, go to CAPTURE.
    - Timeout: if ACK_TO cycles elapse in ACK without this, set err=1 and go to WAIT_REL.
  - CAPTURE, 1 cycle:
    - Push {index of the low bit, timestamp value latched on the IDLE→ACK transition}.
    - Increment ev_count, saturating at 0xFFFF.
    - Go to WAIT_REL.
  - WAIT_REL: hold n_ri=0 until ro_s=0, then go to RELEASE.
  - RELEASE: drive n_ri=1. Wait until g_s is all ones, then go to IDLE.
- Grant validity:
  - More than one low grant bit at the settle point: set err=1, no push, go to WAIT_REL.
  - A grant seen while n_ri=1 (in IDLE): set err=1.
- Address encoding: index of the single 0 bit of g_s, 0..11. Values 12..15 are never produced.
- FIFO:
  - Head is shown on ev_addr/ev_ts while ev_valid=1.
  - Push and pop in the same cycle are legal. Occupancy is unchanged, including when the FIFO is full.
  - The full check in IDLE uses the occupancy of the current cycle. A pop in that cycle does not unblock ack until the next cycle.
  - Event latency: ev_valid rises no earlier than the cycle after CAPTURE.
- Reset mid-handshake: forces n_ri=1 and FSM=IDLE, and flushes the FIFO. A still-high ro is then treated as a new request.
- err is cleared only by rst.

Decomposition:
- Shared package spike_enc_pkg holds:
  - the FSM state enum (IDLE, ACK, CAPTURE, WAIT_REL, RELEASE);
  - the event struct {addr[3:0], ts[TS_W-1:0]};
  - constants ADDR_W=4 and N_TAXEL=12.
- One natural sub-module: aer_evt_fifo (parameterized sync FIFO, depth FIFO_DEPTH, width ADDR_W+TS_W).
- The synchronizers and the FSM are inline in aer_rx_12.

Test Plan:
- Single event: after reset, raise ro, drive n_lno=12'hFDF (bit5 low) 3 cycles after n_ri falls, drop ro after ack, then release grants → exactly one event, ev_addr=5, ev_count=1, n_ri returns to 1, err=0.
- Back-to-back: requests for taxels 0, 11, 6 with ev_ready=1 → ev_addr sequence 0, 11, 6 in order, with strictly increasing ev_ts.
- Backpressure: ev_ready=0 with 4 events accepted (FIFO full), 5th ro raised → n_ri stays 1. Assert ev_ready for 1 cycle → n_ri falls 2 cycles later and the 5th event is captured. No loss, ev_count=5.
- Multi-grant error: n_lno=12'hFFC (bits 0,1 low) during ACK → err=1, no push, handshake still completes (n_ri=0 then 1).
- Timeout: ro high, n_lno held 12'hFFF for ACK_TO cycles → err=1, FSM reaches WAIT_REL, n_ri returns to 1 after ro falls.
- Reset mid-operation: assert rst while in WAIT_REL with 2 events buffered → next cycle n_ri=1, ev_valid=0, ev_count=0, err=0.
